// File: rtl/vec_mul_seq_if.sv
// Handshake and data bundle for vec_mul_seq: operand request channel,
// result channel and the busy status flag.
interface vec_mul_seq_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     data_in_A;
  logic [DATA_W-1:0]     data_in_B;
  logic [1:0]            sew;
  logic                  is_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   data_out;
  logic                  busy;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, data_in_A, data_in_B, sew, is_signed, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, data_in_A, data_in_B, sew, is_signed, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/vec_mul_seq.sv
// Handshaked packed-SIMD integer multiplier. Element operands are reduced to
// magnitudes at accept time, their 8x8 partial products are streamed through
// NUM_MULT multipliers over one or more passes and accumulated per element,
// and the per-element sign is restored when the last pass completes.
// The bus interface instance must be built with the same DATA_W.
module vec_mul_seq #(
  parameter int DATA_W   = 32,
  parameter int NUM_MULT = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  vec_mul_seq_if.slave   bus
);

  localparam int NB = DATA_W / 8;   // operand bytes == 16-bit result chunks
  localparam int W2 = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [3:0]          pass_r;
  logic [W2-1:0]       acc_r;
  logic [W2-1:0]       acc_next_s;
  logic [DATA_W-1:0]   a_mag_r;
  logic [DATA_W-1:0]   b_mag_r;
  logic [NB-1:0]       neg_r;        // per byte: owning element needs negation
  logic [1:0]          sew_r;
  logic                out_valid_r;
  logic                busy_r;
  logic [W2-1:0]       data_out_r;
  logic                in_ready_s;
  logic                accept_s;
  logic                illegal_s;
  logic [1:0]          n_log_s;      // log2(bytes per element) of the held op
  logic [1:0]          in_n_log_s;   // same, for the operands being offered
  logic [5:0]          passes_s;
  logic                last_pass_s;
  logic [W2-1:0]       result_s;

  // Per-element conditional two's-complement negation of an operand word.
  // The most negative value maps onto its unsigned magnitude (e.g. 0x80 -> 128).
  function automatic logic [DATA_W-1:0] op_mag(input logic [DATA_W-1:0] x,
                                               input logic [1:0] n_log,
                                               input logic sgn);
    logic [DATA_W-1:0] r;
    logic [8:0]        s;
    logic              c;
    logic              neg;
    int                n;
    r   = '0;
    c   = 1'b0;
    neg = 1'b0;
    n   = 1 << n_log;
    for (int j = 0; j < NB; j++) begin
      if ((j % n) == 0) begin
        neg = sgn & x[8*(j+n)-1];
        c   = neg;
      end else begin
        c = c;
      end
      s = {1'b0, x[8*j +: 8] ^ {8{neg}}} + {8'd0, c};
      r[8*j +: 8] = s[7:0];
      c = s[8];
    end
    return r;
  endfunction

  // Per byte: 1 when the element holding that byte has differing operand signs.
  function automatic logic [NB-1:0] neg_flags(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [1:0] n_log,
                                              input logic sgn);
    logic [NB-1:0] f;
    int            n;
    int            top;
    f = '0;
    n = 1 << n_log;
    for (int j = 0; j < NB; j++) begin
      top  = 8 * ((j / n) * n + n) - 1;
      f[j] = sgn & (a[top] ^ b[top]);
    end
    return f;
  endfunction

  // Lane-wise add: 2*SEW-bit lanes, carries stop at every lane boundary.
  function automatic logic [W2-1:0] lane_add(input logic [W2-1:0] a,
                                             input logic [W2-1:0] b,
                                             input logic [1:0] n_log);
    logic [W2-1:0] r;
    logic [16:0]   s;
    logic          c;
    int            n;
    r = '0;
    c = 1'b0;
    n = 1 << n_log;
    for (int j = 0; j < NB; j++) begin
      if ((j % n) == 0) begin
        c = 1'b0;
      end else begin
        c = c;
      end
      s = {1'b0, a[16*j +: 16]} + {1'b0, b[16*j +: 16]} + {16'd0, c};
      r[16*j +: 16] = s[15:0];
      c = s[16];
    end
    return r;
  endfunction

  // One pass: evaluate entries pass*NUM_MULT .. +NUM_MULT-1 of the partial
  // product list (B byte outermost, then element, then A byte) and add them.
  function automatic logic [W2-1:0] pass_sum(input logic [W2-1:0] acc,
                                             input logic [DATA_W-1:0] am,
                                             input logic [DATA_W-1:0] bm,
                                             input logic [3:0] pass,
                                             input logic [1:0] n_log);
    logic [W2-1:0] sum;
    logic [W2-1:0] term;
    logic [15:0]   pp;
    int            n;
    int            e;
    int            a_pos;
    int            bb;
    int            a_byte;
    int            base;
    sum = acc;
    n   = 1 << n_log;
    for (int k = 0; k < NUM_MULT; k++) begin
      e = int'(pass) * NUM_MULT + k;
      if (e < NB * n) begin
        a_pos  = e % NB;            // absolute A byte = element*n + a_byte
        bb     = e / NB;            // B byte within the element
        a_byte = a_pos % n;
        base   = a_pos - a_byte;    // first byte of the element
        pp     = {8'd0, am[8*a_pos +: 8]} * {8'd0, bm[8*(base+bb) +: 8]};
        term   = {{(W2-16){1'b0}}, pp} << (16*base + 8*(a_byte + bb));
        sum    = lane_add(sum, term, n_log);
      end else begin
        sum = sum;
      end
    end
    return sum;
  endfunction

  // Restore element signs: invert flagged lanes and add one at their LSB.
  function automatic logic [W2-1:0] fix_sign(input logic [W2-1:0] acc,
                                             input logic [NB-1:0] neg,
                                             input logic [1:0] n_log);
    logic [W2-1:0] mask;
    logic [W2-1:0] inc;
    int            n;
    mask = '0;
    inc  = '0;
    n    = 1 << n_log;
    for (int j = 0; j < NB; j++) begin
      mask[16*j +: 16] = {16{neg[j]}};
      if ((j % n) == 0) begin
        inc[16*j +: 16] = {15'd0, neg[j]};
      end else begin
        inc[16*j +: 16] = 16'd0;
      end
    end
    return lane_add(acc ^ mask, inc, n_log);
  endfunction

  assign in_ready_s  = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign illegal_s   = (sew_r == 2'b11);
  assign n_log_s     = illegal_s ? 2'd0 : sew_r;
  assign in_n_log_s  = (bus.sew == 2'b11) ? 2'd0 : bus.sew;

  // Pass bookkeeping and datapath for the operation in flight
  always_comb begin
    passes_s = 6'd1;
    if ((6'(NB) << n_log_s) > 6'(NUM_MULT)) begin
      passes_s = (6'(NB) << n_log_s) / 6'(NUM_MULT);
    end else begin
      passes_s = 6'd1;
    end
    last_pass_s = illegal_s || ({2'b00, pass_r} == (passes_s - 6'd1));
    acc_next_s  = pass_sum(acc_r, a_mag_r, b_mag_r, pass_r, n_log_s);
    result_s    = illegal_s ? {W2{1'b0}} : fix_sign(acc_next_s, neg_r, n_log_s);
  end

  // Next-state logic of the IDLE/CALC/DONE controller
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = CALC;
        else          state_next_s = IDLE;
      end
      CALC: begin
        if (last_pass_s) state_next_s = DONE;
        else             state_next_s = CALC;
      end
      DONE: begin
        if (bus.out_ready) state_next_s = bus.in_valid ? CALC : IDLE;
        else               state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand capture, accumulation and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      pass_r      <= 4'd0;
      acc_r       <= {W2{1'b0}};
      a_mag_r     <= {DATA_W{1'b0}};
      b_mag_r     <= {DATA_W{1'b0}};
      neg_r       <= {NB{1'b0}};
      sew_r       <= 2'b00;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      data_out_r  <= {W2{1'b0}};
    end else begin
      state_r     <= state_next_s;
      busy_r      <= (state_next_s == CALC);
      out_valid_r <= (state_next_s == DONE);
      if (accept_s) begin
        a_mag_r <= op_mag(bus.data_in_A, in_n_log_s, bus.is_signed);
        b_mag_r <= op_mag(bus.data_in_B, in_n_log_s, bus.is_signed);
        neg_r   <= neg_flags(bus.data_in_A, bus.data_in_B, in_n_log_s, bus.is_signed);
        sew_r   <= bus.sew;
        acc_r   <= {W2{1'b0}};
        pass_r  <= 4'd0;
      end else if (state_r == CALC) begin
        acc_r  <= acc_next_s;
        pass_r <= pass_r + 4'd1;
        if (last_pass_s) data_out_r <= result_s;
        else             data_out_r <= data_out_r;
      end else begin
        acc_r  <= acc_r;
        pass_r <= pass_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.data_out  = data_out_r;
  assign bus.busy      = busy_r;

endmodule
